// File: rtl/fish_sched_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : fish_sched_pkg                                               |
// | Description : Shared types and constants for the Twofish job scheduler.    |
// |               Holds the data/key types, the operation encoding, the        |
// |               scheduler state encoding and the datapath busy grace time.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package fish_sched_pkg;

    typedef logic [127:0] block_t;
    typedef logic [127:0] key_t;

    typedef enum logic {
        OP_ENC = 1'b0,
        OP_DEC = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        RESP      = 3'd4
    } sched_state_e;

    // Cycles to wait for dp_busy after Start before assuming the datapath
    // finished the job with zero latency.
    localparam int DP_BUSY_GRACE = 2;

endpackage

`default_nettype wire

// File: rtl/fish_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : fish_rr_arbiter                                              |
// | Description : Combinational round-robin arbiter. Search starts one above   |
// |               the last granted index and wraps from NUM_REQ-1 back to 0.   |
// |               A grant is only raised for an asserting requester.           |
// | Ports       : i_req      - request vector                                  |
// |               i_rr_ptr   - index of the most recently granted requester    |
// |               o_grant    - one-hot grant (zero when no request)            |
// |               o_grant_id - index of the granted requester                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fish_rr_arbiter
    import fish_sched_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id
);

    // One extra bit so rr_ptr + offset (at most 2*NUM_REQ-1) does not overflow
    // before the single wrap subtraction.
    logic [ID_W:0] w_idx;
    logic          w_found;

    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, i_rr_ptr} + (ID_W + 1)'(i + 1);
            if (w_idx >= (ID_W + 1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W + 1)'(NUM_REQ);
            end
            if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
                w_found                    = 1'b1;
                o_grant[w_idx[ID_W-1:0]]   = 1'b1;
                o_grant_id                 = w_idx[ID_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fish_job_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : fish_job_scheduler                                           |
// | Description : Arbitrates encrypt/decrypt jobs from NUM_REQ requesters onto |
// |               a single Twofish datapath. One job in flight at a time:      |
// |               grant, Start pulse, busy tracking, result capture and a      |
// |               tagged response held until accepted.                         |
// | Ports       : Clk, Reset           - clock, synchronous active-high reset  |
// |               req_valid/req_ready  - per-requester handshake (one-hot rdy) |
// |               req_ende/block/key   - per-requester job fields              |
// |               rsp_valid/rsp_ready  - response handshake                    |
// |               rsp_id/data/err      - response tag, result, watchdog abort  |
// |               dp_block/key/EnDe    - job operands to the datapath          |
// |               dp_Start             - one-cycle start pulse                 |
// |               dp_o, dp_busy        - datapath result and busy flag         |
// | Options     : FISH_WDOG_EN - builds a watchdog that aborts a job after     |
// |               TIMEOUT_CYCLES cycles in WAIT_BUSY/RUN (rsp_err=1, data=0).  |
// |               Undefined: no counter, rsp_err stays 0, RUN waits forever.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fish_job_scheduler
    import fish_sched_pkg::*;
#(
    parameter int  NUM_REQ        = 2,     // legal range 2..8
`ifdef FISH_WDOG_EN
    parameter int  TIMEOUT_CYCLES = 64,
`endif
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_ende,
    input  logic [NUM_REQ-1:0][127:0] req_block,
    input  logic [NUM_REQ-1:0][127:0] req_key,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [127:0]              rsp_data,
    output logic                      rsp_err,
    output logic [127:0]              dp_block,
    output logic [127:0]              dp_key,
    output logic                      dp_EnDe,
    output logic                      dp_Start,
    input  logic [127:0]              dp_o,
    input  logic                      dp_busy
);

    sched_state_e     r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    block_t           r_job_block;
    key_t             r_job_key;
    op_e              r_job_op;
    logic [ID_W-1:0]  r_job_id;
    logic [1:0]       r_grace;
    logic             r_dp_start;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    block_t           r_rsp_data;
    logic             r_rsp_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_handshake;
    logic               w_timeout;

    fish_rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .i_req      (req_valid),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    // Grants only exist in IDLE; gating with Reset keeps a handshake from
    // being seen while the scheduler is being cleared.
    assign req_ready   = (r_state == IDLE && !Reset) ? w_grant : '0;
    assign w_handshake = |req_ready;

`ifdef FISH_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;

    // Cleared on the handshake edge (i.e. on entry to ISSUE), counts every
    // cycle spent waiting on the datapath.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wdog <= '0;
        end else if (r_state == IDLE && w_handshake) begin
            r_wdog <= '0;
        end else if (r_state == WAIT_BUSY || r_state == RUN) begin
            r_wdog <= r_wdog + WDOG_W'(1);
        end
    end

    assign w_timeout = (r_state == WAIT_BUSY || r_state == RUN) &&
                       (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= ID_W'(NUM_REQ - 1);
            r_job_block <= '0;
            r_job_key   <= '0;
            r_job_op    <= OP_ENC;
            r_job_id    <= '0;
            r_grace     <= '0;
            r_dp_start  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_dp_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_job_block <= req_block[w_grant_id];
                        r_job_key   <= req_key[w_grant_id];
                        r_job_op    <= op_e'(req_ende[w_grant_id]);
                        r_job_id    <= w_grant_id;
                        r_rr_ptr    <= w_grant_id;
                        r_dp_start  <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_grace <= '0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // Normal completion has priority over a coincident timeout.
                    if (!dp_busy && r_grace == 2'(DP_BUSY_GRACE - 1)) begin
                        r_rsp_data  <= dp_o;
                        r_rsp_err   <= 1'b0;
                        r_rsp_id    <= r_job_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_timeout) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_id    <= r_job_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (dp_busy) begin
                        r_state <= RUN;
                    end else begin
                        r_grace <= r_grace + 2'd1;
                    end
                end
                RUN: begin
                    if (!dp_busy) begin
                        r_rsp_data  <= dp_o;
                        r_rsp_err   <= 1'b0;
                        r_rsp_id    <= r_job_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_timeout) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_id    <= r_job_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dp_block  = r_job_block;
    assign dp_key    = r_job_key;
    assign dp_EnDe   = r_job_op;
    assign dp_Start  = r_dp_start;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_fish_job_scheduler.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_fish_job_scheduler                                        |
// | Description : Directed self-checking bench for fish_job_scheduler with a   |
// |               behavioural datapath (programmable busy length, stuck mode). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fish_job_scheduler;
    import fish_sched_pkg::*;

    localparam int     NUM_REQ = 2;
    localparam int     ID_W    = 1;
    localparam block_t REF_CT  = 128'h9F589F5CF6122C32B6BFEC2F2AE8C35A;
    localparam block_t MIX_C   = 128'hA5A50F0F3C3C5A5AC3C3F0F012345678;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_ende = '0;
    logic [NUM_REQ-1:0][127:0] req_block = '0;
    logic [NUM_REQ-1:0][127:0] req_key = '0;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b0;
    logic [ID_W-1:0]           rsp_id;
    logic [127:0]              rsp_data;
    logic                      rsp_err;
    logic [127:0]              dp_block;
    logic [127:0]              dp_key;
    logic                      dp_EnDe;
    logic                      dp_Start;
    logic [127:0]              dp_o = '0;
    logic                      dp_busy = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_lat   = 20;
    bit m_stuck = 1'b0;
    int m_cnt   = 0;

    fish_job_scheduler #(
        .NUM_REQ (NUM_REQ)
    ) dut (
        .Clk       (clk),
        .Reset     (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ende  (req_ende),
        .req_block (req_block),
        .req_key   (req_key),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .dp_block  (dp_block),
        .dp_key    (dp_key),
        .dp_EnDe   (dp_EnDe),
        .dp_Start  (dp_Start),
        .dp_o      (dp_o),
        .dp_busy   (dp_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in cipher: the published all-zero Twofish vector plus an
    // invertible mix for every other block/key pair.
    function automatic block_t model_fn(block_t b, key_t k, logic e);
        block_t x;
        if (!e && b == '0 && k == '0) return REF_CT;
        if (e && b == REF_CT && k == '0) return '0;
        if (!e) begin
            x = b ^ k;
            return {x[114:0], x[127:115]} ^ MIX_C;
        end
        x = b ^ MIX_C;
        return {x[12:0], x[127:13]} ^ k;
    endfunction

    // Datapath model: busy for m_lat cycles after Start (0 = zero latency).
    always @(posedge clk) begin
        if (rst) begin
            dp_busy <= 1'b0;
            m_cnt   <= 0;
        end else if (dp_Start) begin
            dp_o <= model_fn(dp_block, dp_key, dp_EnDe);
            if (m_stuck) begin
                dp_busy <= 1'b1;
            end else if (m_lat == 0) begin
                dp_busy <= 1'b0;
            end else begin
                dp_busy <= 1'b1;
                m_cnt   <= m_lat - 1;
            end
        end else if (dp_busy && !m_stuck) begin
            if (m_cnt == 0) dp_busy <= 1'b0;
            else            m_cnt   <= m_cnt - 1;
        end
    end

    // Always-on protocol monitors.
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
        end else begin
            total++;
            if (dp_Start && prev_start) begin
                bad++;
                $display("FAIL start_pulse_width: dp_Start high two cycles at cyc %0d", cyc);
            end
            total++;
            if ((req_ready & (req_ready - 2'd1)) != '0) begin
                bad++;
                $display("FAIL ready_onehot: req_ready=%b", req_ready);
            end
            total++;
            if (dp_Start && dp_busy) begin
                bad++;
                $display("FAIL start_while_busy: dp_Start=1 dp_busy=1 at cyc %0d", cyc);
            end
            prev_start = dp_Start;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int id, input block_t b, input key_t k, input logic e,
                             output int hs, output bit ok);
        req_block[id] = b;
        req_key[id]   = k;
        req_ende[id]  = e;
        req_valid[id] = 1'b1;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        hs = cyc;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (rsp_valid) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        tick();
        tick();
        total++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 ||
            rsp_err !== 1'b0 || dp_block !== '0 || dp_key !== '0 || dp_EnDe !== 1'b0 ||
            dp_Start !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b rv=%b id=%0d data=%h err=%b blk=%h key=%h ende=%b start=%b, required all 0",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, dp_block, dp_key, dp_EnDe, dp_Start);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        #1;
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL reset_first_grant: req_ready=%b required=01", req_ready);
        end
        req_valid = 2'b00;
        #1;
        total++;
        if (req_ready !== 2'b00) begin
            bad++;
            $display("FAIL idle_no_valid: req_ready=%b required=00", req_ready);
        end
    endtask

    task automatic test_single_encrypt();
        bit ok;
        int hs, at;
        m_lat = 20;
        start_job(0, '0, '0, 1'b0, hs, ok);
        total++;
        if (!ok || dp_Start !== 1'b1) begin
            bad++;
            $display("FAIL enc_start_n1: granted=%b dp_Start=%b required 1/1", ok, dp_Start);
        end
        wait_rsp(100, ok, at);
        total++;
        if (!ok || at != hs + 22) begin
            bad++;
            $display("FAIL enc_latency: rsp at cyc %0d (seen=%b) required %0d", at, ok, hs + 22);
        end
        total++;
        if (rsp_id !== 1'b0 || rsp_data !== REF_CT || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL enc_result: id=%0d data=%h err=%b required id=0 data=%h err=0",
                     rsp_id, rsp_data, rsp_err, REF_CT);
        end
        accept();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL enc_rsp_drop: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_round_trip();
        bit ok;
        int hs, at;
        block_t b = 128'h0123456789ABCDEFFEDCBA9876543210;
        key_t   k = 128'h00112233445566778899AABBCCDDEEFF;
        block_t ct;
        m_lat = 16;
        start_job(1, b, k, 1'b0, hs, ok);
        wait_rsp(100, ok, at);
        total++;
        if (!ok || rsp_id !== 1'b1 || rsp_data !== model_fn(b, k, 1'b0)) begin
            bad++;
            $display("FAIL rt_encrypt: seen=%b id=%0d data=%h required id=1 data=%h",
                     ok, rsp_id, rsp_data, model_fn(b, k, 1'b0));
        end
        ct = rsp_data;
        accept();
        start_job(1, ct, k, 1'b1, hs, ok);
        total++;
        if (dp_EnDe !== 1'b1 || dp_block !== ct || dp_key !== k) begin
            bad++;
            $display("FAIL rt_dp_operands: ende=%b blk=%h key=%h required 1/%h/%h", dp_EnDe, dp_block, dp_key, ct, k);
        end
        wait_rsp(100, ok, at);
        total++;
        if (!ok || rsp_id !== 1'b1 || rsp_data !== b) begin
            bad++;
            $display("FAIL rt_decrypt: seen=%b id=%0d data=%h required id=1 data=%h", ok, rsp_id, rsp_data, b);
        end
        accept();
    endtask

    task automatic test_zero_latency();
        bit ok;
        int hs, at;
        block_t b = 128'hCAFEF00D_00000000_11111111_22222222;
        key_t   k = 128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA;
        for (int lat = 0; lat < 2; lat++) begin
            m_lat = lat;
            start_job(0, b, k, 1'b0, hs, ok);
            wait_rsp(20, ok, at);
            total++;
            if (!ok || at != hs + 3 || rsp_data !== model_fn(b, k, 1'b0) || rsp_id !== 1'b0) begin
                bad++;
                $display("FAIL short_latency_%0d: seen=%b at=%0d required %0d data=%h required %h",
                         lat, ok, at, hs + 3, rsp_data, model_fn(b, k, 1'b0));
            end
            accept();
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [ID_W-1:0] exp_id;
        block_t exp_d;
        int at;
        do_reset();
        m_lat = 3;
        req_block[0] = 128'h1000; req_key[0] = 128'hAB; req_ende[0] = 1'b0;
        req_block[1] = 128'h2000; req_key[1] = 128'hCD; req_ende[1] = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        for (int j = 0; j < 6; j++) begin
            exp_id = ID_W'(j % 2);
            exp_d  = (j % 2 == 0) ? model_fn(128'h1000, 128'hAB, 1'b0) : model_fn(128'h2000, 128'hCD, 1'b0);
            ok = 1'b0;
            for (int t = 0; t < 20; t++) begin
                if (req_ready != '0) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            total++;
            if (!ok || req_ready !== (2'b01 << exp_id)) begin
                bad++;
                $display("FAIL rr_grant_%0d: req_ready=%b required %b", j, req_ready, 2'b01 << exp_id);
            end
            tick();
            wait_rsp(50, ok, at);
            total++;
            if (!ok || rsp_id !== exp_id || rsp_data !== exp_d) begin
                bad++;
                $display("FAIL rr_rsp_%0d: id=%0d data=%h required id=%0d data=%h", j, rsp_id, rsp_data, exp_id, exp_d);
            end
            total++;
            if (req_ready !== 2'b00) begin
                bad++;
                $display("FAIL rr_no_grant_in_resp_%0d: req_ready=%b required 00", j, req_ready);
            end
            tick();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int hs, at;
        block_t b = 128'h0F0E0D0C0B0A09080706050403020100;
        key_t   k = 128'h1;
        block_t exp_d = model_fn(b, k, 1'b0);
        m_lat = 2;
        start_job(0, b, k, 1'b0, hs, ok);
        wait_rsp(50, ok, at);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL bp_rsp_seen: rsp_valid=%b required 1", rsp_valid);
        end
        req_block[1] = 128'h77;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== exp_d || rsp_err !== 1'b0 ||
                req_ready !== 2'b00 || dp_Start !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d: rv=%b id=%0d data=%h err=%b ready=%b start=%b required 1/0/%h/0/00/0",
                         i, rsp_valid, rsp_id, rsp_data, rsp_err, req_ready, dp_Start, exp_d);
            end
        end
        req_valid = 2'b00;
        accept();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int hs, at, seen;
        m_lat = 30;
        start_job(0, 128'h99, 128'h42, 1'b0, hs, ok);
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        total++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 ||
            rsp_err !== 1'b0 || dp_block !== '0 || dp_key !== '0 || dp_EnDe !== 1'b0 ||
            dp_Start !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset_outputs: ready=%b rv=%b data=%h blk=%h key=%h start=%b required all 0",
                     req_ready, rsp_valid, rsp_data, dp_block, dp_key, dp_Start);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrun_no_rsp: rsp_valid seen %0d cycles required 0", seen);
        end
        m_lat = 5;
        start_job(1, 128'h5A, 128'h3C, 1'b0, hs, ok);
        wait_rsp(50, ok, at);
        total++;
        if (!ok || at != hs + 7 || rsp_id !== 1'b1 || rsp_data !== model_fn(128'h5A, 128'h3C, 1'b0)) begin
            bad++;
            $display("FAIL midrun_next_job: seen=%b at=%0d required %0d id=%0d data=%h required %h",
                     ok, at, hs + 7, rsp_id, rsp_data, model_fn(128'h5A, 128'h3C, 1'b0));
        end
        accept();
    endtask

    task automatic test_watchdog();
        bit ok;
        int hs, at;
        m_stuck = 1'b1;
        start_job(0, 128'h1234, 128'h5678, 1'b0, hs, ok);
`ifdef FISH_WDOG_EN
        wait_rsp(200, ok, at);
        total++;
        if (!ok || at != hs + 65 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== 1'b0) begin
            bad++;
            $display("FAIL wdog_abort: seen=%b at=%0d required %0d err=%b data=%h required err=1 data=0",
                     ok, at, hs + 65, rsp_err, rsp_data);
        end
        accept();
`else
        wait_rsp(150, ok, at);
        total++;
        if (ok || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL no_wdog_wait: rsp_valid appeared at cyc %0d err=%b, required no response", at, rsp_err);
        end
`endif
        do_reset();
        m_stuck = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_encrypt();
        test_round_trip();
        test_zero_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        test_watchdog();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
